bus_memory_responder: RTL and testbench

Bus-side responder (slave) for the shared address/data bus used by the DMA initiator. It decodes begin-transaction cycles, claims those whose address falls inside its window, and serves single and burst reads and writes from an internal word-wide synchronous memory. It produces the responder-side signals that an initiator consumes: read data beats, write-side `busy` stalls, read end-of-transaction and `error`. It sits on the bus next to other responders; whenever it is not driving the bus, every output is 0 so the bus can be wired-OR.

---
 rtl/bus_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Bus-side memory responder: decodes begin cycles that fall inside its address
// window and serves single and burst reads/writes from an internal word memory.
// All outputs are 0 whenever the responder is not driving, so it can share a
// wired-OR bus with other responders.
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h5000_0000,
  parameter int unsigned WORD_COUNT_LOG2 = 10,
  parameter int unsigned WAIT_STATES     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned AW = WORD_COUNT_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WSTALL,
    RFETCH,
    READ,
    REND,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [8:0]    beats_q, beats_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          valid_q, valid_d;
  logic          eot_q, eot_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          mem_we;
  logic          hit;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [0:(1<<AW)-1];

  assign hit = (address_dataIN[31:AW+2] == BASE_ADDRESS[31:AW+2]);

  // Next-state, pointer/counter update and memory write enable.
  // The memory is read at ptr_d every cycle, so the word for the next beat is
  // already registered in the cycle after a transfer (no bubble after a stall).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    be_d    = be_q;
    wcnt_d  = wcnt_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_transactionIN && hit) begin
          if (address_dataIN[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            ptr_d   = address_dataIN[AW+1:2];
            beats_d = {1'b0, burst_sizeIN} + 9'd1;
            be_d    = byte_enableIN;
            state_d = read_n_writeIN ? RFETCH : WRITE;
          end
        end
      end
      WRITE: begin
        if (data_validIN) begin
          if (beats_q != 9'd0) begin
            mem_we  = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            beats_d = beats_q - 9'd1;
          end
          if (WAIT_STATES > 0) begin
            state_d = WSTALL;
            wcnt_d  = 3'(WAIT_STATES - 1);
          end
        end
        if (end_transactionIN) state_d = IDLE;
      end
      WSTALL: begin
        if (wcnt_q == 3'd0) state_d = WRITE;
        else                wcnt_d  = wcnt_q - 3'd1;
        if (end_transactionIN) state_d = IDLE;
      end
      RFETCH: begin
        state_d = end_transactionIN ? IDLE : READ;
      end
      READ: begin
        if (!busyIN) begin
          ptr_d = ptr_q + 1'b1;
          if (beats_q == 9'd1) state_d = REND;
          else                 beats_d = beats_q - 9'd1;
        end
        if (end_transactionIN) state_d = IDLE;
      end
      REND:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) mem_we = 1'b0;
    valid_d = (state_d == READ);
    eot_d   = (state_d == REND);
    busy_d  = (state_d == WSTALL);
    error_d = (state_d == ERR);
  end

  // Control state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beats_q <= '0;
      be_q    <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      eot_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      be_q    <= be_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      eot_q   <= eot_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // Word memory with per-lane writes and a registered read port; never reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[ptr_q][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
    rdata_q <= mem[ptr_d];
  end

  assign address_dataOUT    = valid_q ? rdata_q : '0;
  assign data_validOUT      = valid_q;
  assign end_transactionOUT = eot_q;
  assign busyOUT            = busy_q;
  assign errorOUT           = error_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: two responders on one wired-OR bus
// (window 0x5000_0000 with no wait states, window 0x6000_0000 with 2 wait states).
// Read beats are checked against a queue of expected words filled when the read
// is issued.
module tb_bus_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_in = '0;
  logic [3:0]  be_in = '0;
  logic [7:0]  burst_in = '0;
  logic        rnw_in = 1'b0;
  logic        begin_in = 1'b0;
  logic        end_in = 1'b0;
  logic        dv_in = 1'b0;
  logic        busy_in = 1'b0;

  logic [31:0] d0_data, d2_data;
  logic        d0_valid, d2_valid, d0_eot, d2_eot, d0_busy, d2_busy, d0_err, d2_err;

  logic [31:0] bus_data;
  logic        bus_valid, bus_eot, bus_busy, bus_err;
  assign bus_data  = d0_data | d2_data;
  assign bus_valid = d0_valid | d2_valid;
  assign bus_eot   = d0_eot | d2_eot;
  assign bus_busy  = d0_busy | d2_busy;
  assign bus_err   = d0_err | d2_err;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] sb [$];
  logic        busy0_seen = 1'b0;

  always #5 clock = ~clock;

  bus_memory_responder #(
    .BASE_ADDRESS(32'h5000_0000), .WORD_COUNT_LOG2(10), .WAIT_STATES(0)
  ) dut0 (
    .clock(clock), .reset(reset), .address_dataIN(addr_in), .byte_enableIN(be_in),
    .burst_sizeIN(burst_in), .read_n_writeIN(rnw_in), .begin_transactionIN(begin_in),
    .end_transactionIN(end_in), .data_validIN(dv_in), .busyIN(busy_in),
    .address_dataOUT(d0_data), .data_validOUT(d0_valid), .end_transactionOUT(d0_eot),
    .busyOUT(d0_busy), .errorOUT(d0_err)
  );

  bus_memory_responder #(
    .BASE_ADDRESS(32'h6000_0000), .WORD_COUNT_LOG2(10), .WAIT_STATES(2)
  ) dut2 (
    .clock(clock), .reset(reset), .address_dataIN(addr_in), .byte_enableIN(be_in),
    .burst_sizeIN(burst_in), .read_n_writeIN(rnw_in), .begin_transactionIN(begin_in),
    .end_transactionIN(end_in), .data_validIN(dv_in), .busyIN(busy_in),
    .address_dataOUT(d2_data), .data_validOUT(d2_valid), .end_transactionOUT(d2_eot),
    .busyOUT(d2_busy), .errorOUT(d2_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transferred read beat must match the next queued word.
  always @(negedge clock) begin
    if (d0_busy) busy0_seen = 1'b1;
    if (!reset && bus_valid && !busy_in) begin
      total++;
      assert (sb.size() != 0) begin
        passed++;
      end else begin
        $error("FAIL sb_underflow observed=beat %h expected=no beat", bus_data);
      end
      if (sb.size() != 0) chk("sb_beat", bus_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [35:0] all_outs();
    return {bus_data, bus_valid, bus_eot, bus_busy, bus_err};
  endfunction

  task automatic begin_txn(input logic [31:0] addr, input logic [3:0] be,
                           input logic [7:0] burst, input logic rnw);
    addr_in = addr; be_in = be; burst_in = burst; rnw_in = rnw; begin_in = 1'b1;
    step();
    begin_in = 1'b0; addr_in = '0; be_in = '0; burst_in = '0; rnw_in = 1'b0;
  endtask

  // Burst write to the zero-wait responder; end is raised with the last beat.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input int n,
                             input logic [31:0] base, input logic [31:0] inc);
    begin_txn(addr, be, 8'(n - 1), 1'b0);
    for (int i = 0; i < n; i++) begin
      addr_in = base + 32'(i) * inc;
      dv_in   = 1'b1;
      end_in  = (i == n - 1);
      step();
    end
    dv_in = 1'b0; end_in = 1'b0; addr_in = '0;
  endtask

  // Read with busyIN low; expected words must already be queued.
  task automatic read_check(input string tag, input logic [31:0] addr, input logic [7:0] burst);
    int n;
    begin_txn(addr, 4'hF, burst, 1'b1);
    n = 0;
    while (!bus_eot && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_eot_latency"}, 32'(n), 32'(burst) + 32'd2);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    step();
  endtask

  initial begin
    step();
    step();
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    reset = 1'b0;

    // single write then read
    begin_txn(32'h5000_0010, 4'hF, 8'd0, 1'b0);
    chk("wr_busy_low", 32'(bus_busy), 32'd0);
    addr_in = 32'hA5A5_A5A5; dv_in = 1'b1; end_in = 1'b1;
    step();
    dv_in = 1'b0; end_in = 1'b0; addr_in = '0;
    chk("wr_done_idle", 32'(all_outs()), 32'd0);
    sb.push_back(32'hA5A5_A5A5);
    begin_txn(32'h5000_0010, 4'hF, 8'd0, 1'b1);
    chk("rd_rfetch_no_valid", 32'(bus_valid), 32'd0);
    step();
    chk("rd_valid_t2", 32'(bus_valid), 32'd1);
    chk("rd_data_t2", bus_data, 32'hA5A5_A5A5);
    step();
    chk("rd_eot_t3", {30'd0, bus_eot, bus_valid}, 32'd2);
    step();
    chk("rd_idle_t4", 32'(all_outs()), 32'd0);

    // byte lanes
    write_burst(32'h5000_0020, 4'hF, 1, 32'h1122_3344, 32'd0);
    write_burst(32'h5000_0020, 4'b0101, 1, 32'hAABB_CCDD, 32'd0);
    sb.push_back(32'h11BB_33DD);
    read_check("lanes", 32'h5000_0020, 8'd0);

    // wrapping burst from word 1022
    write_burst(32'h5000_0FF8, 4'hF, 4, 32'd1, 32'd1);
    for (int i = 1; i <= 4; i++) sb.push_back(32'(i));
    read_check("wrap4", 32'h5000_0FF8, 8'd3);
    sb.push_back(32'd3);
    read_check("wrap_w0", 32'h5000_0000, 8'd0);
    sb.push_back(32'd4);
    read_check("wrap_w1", 32'h5000_0004, 8'd0);

    // wait-state write on the second responder
    begin_txn(32'h6000_0000, 4'hF, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      addr_in = 32'h10 * 32'(i + 1); dv_in = 1'b1;
      chk("ws_busy_low_at_beat", 32'(bus_busy), 32'd0);
      step();
      chk("ws_busy_k1", 32'(d2_busy), 32'd1);
      step();
      chk("ws_busy_k2", 32'(d2_busy), 32'd1);
      step();
    end
    chk("ws_busy_released", 32'(bus_busy), 32'd0);
    dv_in = 1'b0; end_in = 1'b1; addr_in = '0;
    step();
    end_in = 1'b0;
    chk("ws_end_idle", 32'(all_outs()), 32'd0);

    // stalled read: busyIN high for T+3..T+5
    sb.push_back(32'h10); sb.push_back(32'h20); sb.push_back(32'h30);
    begin_txn(32'h6000_0000, 4'hF, 8'd2, 1'b1);
    step();
    chk("st_beat0", bus_data, 32'h10);
    step();
    busy_in = 1'b1;
    chk("st_beat1_t3", bus_data, 32'h20);
    step();
    chk("st_hold_t4", {bus_data[30:0], bus_valid}, {31'h20, 1'b1});
    step();
    chk("st_hold_t5", {bus_data[30:0], bus_valid}, {31'h20, 1'b1});
    step();
    busy_in = 1'b0;
    chk("st_release_t6", bus_data, 32'h20);
    step();
    chk("st_beat2_t7", bus_data, 32'h30);
    step();
    chk("st_eot_t8", {30'd0, bus_eot, bus_valid}, 32'd2);
    step();
    chk("st_drained", 32'(sb.size()), 32'd0);

    // decode miss
    begin_txn(32'h4000_0000, 4'hF, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("miss_quiet", 32'(all_outs()), 32'd0);
      step();
    end

    // misaligned hit: one error cycle, no write even with a beat presented
    begin_txn(32'h5000_0002, 4'hF, 8'd0, 1'b0);
    chk("err_t1", {28'd0, bus_err, bus_busy, bus_valid, bus_eot}, 32'h8);
    addr_in = 32'hDEAD_BEEF; dv_in = 1'b1;
    step();
    dv_in = 1'b0; addr_in = '0;
    chk("err_t2_clear", 32'(all_outs()), 32'd0);
    sb.push_back(32'd3);
    read_check("err_mem_kept", 32'h5000_0000, 8'd0);

    // read abort at beat 3 of a 16-beat read
    write_burst(32'h5000_0100, 4'hF, 4, 32'h100, 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i));
    begin_txn(32'h5000_0100, 4'hF, 8'd15, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("ab_beat3", bus_data, 32'h103);
    end_in = 1'b1;
    step();
    end_in = 1'b0;
    chk("ab_after", {30'd0, bus_eot, bus_valid}, 32'd0);
    step();
    chk("ab_no_eot", 32'(all_outs()), 32'd0);
    chk("ab_drained", 32'(sb.size()), 32'd0);

    // reset during an 8-beat write at beat 2
    write_burst(32'h5000_0200, 4'hF, 8, 32'hFFFF_FFFF, 32'd0);
    begin_txn(32'h5000_0200, 4'hF, 8'd7, 1'b0);
    addr_in = 32'h200; dv_in = 1'b1;
    step();
    addr_in = 32'h201;
    step();
    addr_in = 32'h202; reset = 1'b1;
    step();
    reset = 1'b0; dv_in = 1'b0; addr_in = '0;
    chk("rst_mid_outputs", 32'(all_outs()), 32'd0);
    sb.push_back(32'h200); sb.push_back(32'h201);
    for (int i = 0; i < 6; i++) sb.push_back(32'hFFFF_FFFF);
    read_check("rst_readback", 32'h5000_0200, 8'd7);

    chk("nows_busy_never", 32'(busy0_seen), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
